// File: rtl/nr_divider_param.sv
`default_nettype none
// ============================================================================
//  Module   : nr_divider_param
//  Purpose  : Iterative non-restoring divider. Takes a 2W-bit dividend and a
//             W-bit divisor, returns a W-bit quotient and a W-bit remainder.
//             Supports signed or unsigned operation, with divide-by-zero and
//             overflow flags. One quotient bit is produced per clock, and only
//             one operation is in flight at a time.
//  Ports    : clock, reset      - rising-edge clock, async active-high reset
//             in_valid/in_ready - operand handshake (signed_op, numerator,
//                                 denominator are sampled when both are high)
//             out_valid/out_ready - result handshake (quotient, remainder,
//                                 div_zero, overflow are held until taken)
//  Revision : 1.0  initial release
// ============================================================================
module nr_divider_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_op,
    input  logic [2*WIDTH-1:0]   numerator,
    input  logic [WIDTH-1:0]     denominator,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
    output logic                 overflow
);

    localparam int c_NW    = 2 * WIDTH;
    localparam int c_ACC_W = 2 * WIDTH + 1;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_HALF = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_ITER  = 3'd2;
    localparam logic [2:0] c_FIX   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;

    logic [c_NW-1:0]     r_num;
    logic [WIDTH-1:0]    r_den;
    logic                r_signed;
    logic [WIDTH-1:0]    r_dmag;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [c_ACC_W-1:0]  r_a;
    logic                r_lsb;
    logic [c_CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]    r_quotient;
    logic [WIDTH-1:0]    r_remainder;
    logic                r_div_zero;
    logic                r_overflow;

    // Operand magnitudes, formed from the latched operands.
    logic                w_n_neg;
    logic                w_d_neg;
    logic [c_NW-1:0]     w_n_mag;
    logic [WIDTH-1:0]    w_d_mag;
    logic                w_d_zero;
    logic                w_pre_ovf;

    assign w_n_neg   = r_signed & r_num[c_NW-1];
    assign w_d_neg   = r_signed & r_den[WIDTH-1];
    assign w_n_mag   = w_n_neg ? ({c_NW{1'b0}} - r_num) : r_num;
    assign w_d_mag   = w_d_neg ? ({WIDTH{1'b0}} - r_den) : r_den;
    assign w_d_zero  = (w_d_mag == {WIDTH{1'b0}});
    // A high half at or above the divisor means |Q| >= 2^W.
    assign w_pre_ovf = (w_n_mag[c_NW-1:WIDTH] >= w_d_mag);

    // One non-restoring step. The previous quotient bit is OR-ed into bit 0
    // before the shift so it lands in the vacated slot; the add/subtract
    // choice follows the sign of the partial remainder before shifting.
    logic [c_ACC_W-1:0]  w_d_shift;
    logic [c_ACC_W-1:0]  w_shifted;
    logic [c_ACC_W-1:0]  w_sum;

    assign w_d_shift = {1'b0, r_dmag, {WIDTH{1'b0}}};
    assign w_shifted = (r_a | {{(c_ACC_W-1){1'b0}}, r_lsb}) << 1;
    assign w_sum     = r_a[c_ACC_W-1] ? (w_shifted + w_d_shift)
                                      : (w_shifted - w_d_shift);

    // Final correction. The restore only touches the remainder field, and the
    // corrected remainder lies in [0,|D|), so W-bit modular arithmetic is exact.
    logic [c_ACC_W-1:0]  w_fix_a;
    logic [WIDTH-1:0]    w_qu;
    logic [WIDTH-1:0]    w_ru;
    logic                w_post_ovf;
    logic [WIDTH-1:0]    w_q_out;
    logic [WIDTH-1:0]    w_r_out;

    assign w_fix_a    = r_a | {{(c_ACC_W-1){1'b0}}, r_lsb};
    assign w_qu       = w_fix_a[WIDTH-1:0];
    assign w_ru       = w_fix_a[c_ACC_W-1] ? (w_fix_a[c_NW-1:WIDTH] + r_dmag)
                                           : w_fix_a[c_NW-1:WIDTH];
    // A negative result may reach -2^(W-1); a positive one stops at 2^(W-1)-1.
    assign w_post_ovf = r_signed & (r_neg_q ? (w_qu > c_HALF) : w_qu[WIDTH-1]);
    assign w_q_out    = r_neg_q ? ({WIDTH{1'b0}} - w_qu) : w_qu;
    assign w_r_out    = r_neg_r ? ({WIDTH{1'b0}} - w_ru) : w_ru;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) w_state_next = c_CHECK;
            end
            c_CHECK: begin
                if (w_d_zero || w_pre_ovf) w_state_next = c_DONE;
                else                       w_state_next = c_ITER;
            end
            c_ITER: begin
                if (r_count == c_LAST) w_state_next = c_FIX;
            end
            c_FIX: begin
                w_state_next = c_DONE;
            end
            c_DONE: begin
                if (out_ready) w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num       <= '0;
            r_den       <= '0;
            r_signed    <= 1'b0;
            r_dmag      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_a         <= '0;
            r_lsb       <= 1'b0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_num    <= numerator;
                        r_den    <= denominator;
                        r_signed <= signed_op;
                    end
                end
                c_CHECK: begin
                    r_dmag  <= w_d_mag;
                    r_neg_q <= w_n_neg ^ w_d_neg;
                    r_neg_r <= w_n_neg;
                    r_a     <= {1'b0, w_n_mag};
                    r_lsb   <= 1'b0;
                    r_count <= '0;
                    if (w_d_zero) begin
                        r_div_zero  <= 1'b1;
                        r_overflow  <= 1'b0;
                        r_quotient  <= '1;
                        r_remainder <= r_num[WIDTH-1:0];
                    end else if (w_pre_ovf) begin
                        r_div_zero  <= 1'b0;
                        r_overflow  <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else begin
                        r_div_zero  <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                c_ITER: begin
                    r_a     <= w_sum;
                    r_lsb   <= ~w_sum[c_ACC_W-1];
                    r_count <= r_count + c_CNT_W'(1);
                end
                c_FIX: begin
                    if (w_post_ovf) begin
                        r_overflow  <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= w_q_out;
                        r_remainder <= w_r_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nr_divider_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_nr_divider_param
//  Purpose  : Self-checking bench for nr_divider_param (WIDTH=8): reset state,
//             directed vectors, back-pressure, mid-operation reset and random
//             signed/unsigned operands against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nr_divider_param;

    localparam int W       = 8;
    localparam int NW      = 2 * W;
    localparam int POS_MAX = 2**(W-1) - 1;
    localparam int NEG_MIN = -(2**(W-1));
    localparam int N_RAND  = 1500;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            signed_op;
    logic [NW-1:0]   numerator;
    logic [W-1:0]    denominator;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    quotient;
    logic [W-1:0]    remainder;
    logic            div_zero;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nr_divider_param #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_op   (signed_op),
        .numerator   (numerator),
        .denominator (denominator),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .overflow    (overflow)
    );

    // Reference: plain integer division (truncating toward zero) plus range rules.
    function automatic void model(input logic s, input logic [NW-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov, output int lat);
        longint nn, dd, qq, rr, qmag;
        if (s) begin
            nn = $signed(n);
            dd = $signed(d);
        end else begin
            nn = n;
            dd = d;
        end
        dz = 1'b0; ov = 1'b0; lat = W + 2;
        if (dd == 0) begin
            dz = 1'b1; q = '1; r = n[W-1:0]; lat = 1;
        end else begin
            qq = nn / dd;
            rr = nn % dd;
            qmag = (qq < 0) ? -qq : qq;
            if (qmag >= (longint'(1) << W)) lat = 1;
            if (s) ov = (qq > POS_MAX) || (qq < NEG_MIN);
            else   ov = (qq >= (longint'(1) << W));
            if (ov) begin
                q = '1; r = '0;
            end else begin
                q = qq[W-1:0]; r = rr[W-1:0];
            end
        end
    endfunction

    // Present one operation and wait for its result; no consumption.
    task automatic do_op(input logic s, input logic [NW-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov, output int lat, output logic to);
        int waited;
        to = 1'b0; lat = 0; waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clock); #1; waited++;
        end
        if (!in_ready) to = 1'b1;
        in_valid = 1'b1; signed_op = s; numerator = n; denominator = d;
        @(posedge clock); #1;
        // Scramble inputs to confirm the operands were latched.
        in_valid = 1'b0; signed_op = ~s;
        numerator = NW'($urandom); denominator = W'($urandom);
        while (!out_valid && lat < 60) begin
            @(posedge clock); #1; lat++;
        end
        if (!out_valid) to = 1'b1;
        q = quotient; r = remainder; dz = div_zero; ov = overflow;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_zero, overflow} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want 1 0 00 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_zero, overflow);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic          s;
        logic [NW-1:0] n;
        logic [W-1:0]  d;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dz;
        logic          ov;
        int            lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[15];
        logic [W-1:0] q, r;
        logic dz, ov, to;
        int lat;
        v[0]  = '{1'b0, 16'd3550,  8'd113,  8'd31,  8'd47,  1'b0, 1'b0, W+2};
        v[1]  = '{1'b0, 16'd100,   8'd17,   8'd5,   8'd15,  1'b0, 1'b0, W+2};
        v[2]  = '{1'b0, 16'd100,   8'd16,   8'd6,   8'd4,   1'b0, 1'b0, W+2};
        v[3]  = '{1'b0, 16'h1234,  8'h10,   8'hFF,  8'h00,  1'b0, 1'b1, 1};
        v[4]  = '{1'b0, 16'd500,   8'd0,    8'hFF,  8'hF4,  1'b1, 1'b0, 1};
        v[5]  = '{1'b1, 16'hFF9C,  8'h07,   8'hF2,  8'hFE,  1'b0, 1'b0, W+2};
        v[6]  = '{1'b1, 16'h0064,  8'hF9,   8'hF2,  8'h02,  1'b0, 1'b0, W+2};
        v[7]  = '{1'b1, 16'h8000,  8'hFF,   8'hFF,  8'h00,  1'b0, 1'b1, 1};
        v[8]  = '{1'b1, 16'hFF80,  8'h01,   8'h80,  8'h00,  1'b0, 1'b0, W+2};
        v[9]  = '{1'b1, 16'h0080,  8'h01,   8'hFF,  8'h00,  1'b0, 1'b1, W+2};
        v[10] = '{1'b1, 16'hFFFB,  8'h00,   8'hFF,  8'hFB,  1'b1, 1'b0, 1};
        v[11] = '{1'b0, 16'hFEFF,  8'hFF,   8'hFF,  8'hFE,  1'b0, 1'b0, W+2};
        v[12] = '{1'b0, 16'hFF00,  8'hFF,   8'hFF,  8'h00,  1'b0, 1'b1, 1};
        v[13] = '{1'b1, 16'h3F80,  8'h7F,   8'hFF,  8'h00,  1'b0, 1'b1, W+2};
        v[14] = '{1'b1, 16'hC080,  8'h7F,   8'h80,  8'h00,  1'b0, 1'b0, W+2};
        for (int i = 0; i < 15; i++) begin
            do_op(v[i].s, v[i].n, v[i].d, q, r, dz, ov, lat, to);
            checks++;
            if ({q, r, dz, ov, to} !== {v[i].q, v[i].r, v[i].dz, v[i].ov, 1'b0} || lat != v[i].lat) begin
                errors++;
                $display("FAIL directed[%0d] got q=%h r=%h dz=%b ov=%b lat=%0d to=%b want q=%h r=%h dz=%b ov=%b lat=%0d",
                         i, q, r, dz, ov, lat, to, v[i].q, v[i].r, v[i].dz, v[i].ov, v[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q, r;
        logic dz, ov, to;
        int lat;
        do_op(1'b0, 16'd100, 8'd17, q, r, dz, ov, lat, to);
        checks++;
        if ({q, r, dz, ov, to} !== {8'd5, 8'd15, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_result got q=%h r=%h dz=%b ov=%b to=%b want 05 0f 0 0 0", q, r, dz, ov, to);
        end
        // Offer another operand while stalled; it must not be taken.
        in_valid = 1'b1; numerator = 16'd3550; denominator = 8'd113;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if ({out_valid, in_ready, quotient, remainder, div_zero, overflow} !==
                {1'b1, 1'b0, 8'd5, 8'd15, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b rdy=%b q=%h r=%h want 1 0 05 0f",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        // Back-to-back: accepted the cycle after consumption.
        do_op(1'b0, 16'd100, 8'd16, q, r, dz, ov, lat, to);
        checks++;
        if ({q, r, to} !== {8'd6, 8'd4, 1'b0} || lat != W + 2) begin
            errors++;
            $display("FAIL back_to_back got q=%h r=%h lat=%0d to=%b want 06 04 lat=%0d", q, r, lat, to, W + 2);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic dz, ov, to;
        int lat;
        in_valid = 1'b1; signed_op = 1'b0; numerator = 16'd3550; denominator = 8'd113;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, quotient, remainder, div_zero, overflow} !==
            {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got vld=%b rdy=%b q=%h r=%h dz=%b ov=%b want 0 1 00 00 0 0",
                     out_valid, in_ready, quotient, remainder, div_zero, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        do_op(1'b0, 16'd100, 8'd15, q, r, dz, ov, lat, to);
        checks++;
        if ({q, r, dz, ov, to} !== {8'd6, 8'd10, 1'b0, 1'b0, 1'b0} || lat != W + 2) begin
            errors++;
            $display("FAIL after_reset got q=%h r=%h dz=%b ov=%b lat=%0d to=%b want 06 0a 0 0 lat=%0d",
                     q, r, dz, ov, lat, to, W + 2);
        end
        consume();
    endtask

    task automatic test_random(input logic s);
        logic [NW-1:0] n;
        logic [W-1:0]  d, q, r, eq, er;
        logic          dz, ov, to, edz, eov;
        int            lat, elat, sh;
        longint        nn, dd, qs, rs, rmag, dmag;
        for (int i = 0; i < N_RAND; i++) begin
            n  = NW'($urandom);
            sh = $urandom_range(0, W + 2);
            if (s) n = $signed(n) >>> sh;
            else   n = n >> sh;
            case ($urandom_range(0, 15))
                0:       d = '0;
                1, 2, 3: begin
                    d = W'($urandom_range(1, 3));
                    if (s && $urandom_range(0, 1) == 1) d = -d;
                end
                default: d = W'($urandom);
            endcase
            model(s, n, d, eq, er, edz, eov, elat);
            do_op(s, n, d, q, r, dz, ov, lat, to);
            consume();
            checks++;
            if ({q, r, dz, ov, to} !== {eq, er, edz, eov, 1'b0} || lat != elat) begin
                errors++;
                $display("FAIL random s=%b n=%h d=%h got q=%h r=%h dz=%b ov=%b lat=%0d to=%b want q=%h r=%h dz=%b ov=%b lat=%0d",
                         s, n, d, q, r, dz, ov, lat, to, eq, er, edz, eov, elat);
            end
            if (!edz && !eov) begin
                if (s) begin
                    nn = $signed(n); dd = $signed(d); qs = $signed(q); rs = $signed(r);
                end else begin
                    nn = n; dd = d; qs = q; rs = r;
                end
                rmag = (rs < 0) ? -rs : rs;
                dmag = (dd < 0) ? -dd : dd;
                checks++;
                if (nn != dd * qs + rs || rmag >= dmag || (rs != 0 && ((rs < 0) != (nn < 0)))) begin
                    errors++;
                    $display("FAIL identity s=%b n=%0d d=%0d got q=%0d r=%0d", s, nn, dd, qs, rs);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_op = 1'b0;
        numerator = '0; denominator = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
